sig_gen_sequencer: RTL and testbench

Step sequencer that drives one DDS + signal-generator channel through a programmable list of waveform steps. Each step sets the DDS phase increment, waveform type, amplitude scale and duration. The block sits between the PS-side configuration registers and the DDS compiler / signal-generator pair of one DAC channel. Because the signal generator latches its waveform type only while held in reset, the sequencer also issues that generator's reset pulse whenever the type changes.

---
 rtl/sig_gen_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_sig_gen_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_gen_sequencer.sv
// Waveform step sequencer for one DDS + signal-generator DAC channel.
// Plays a table of {pinc, type, amp, dur} steps and resyncs the generator on type changes.
module sig_gen_sequencer #(
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned PINC_WIDTH = 32,
  parameter int unsigned AMP_WIDTH  = 16,
  parameter int unsigned DUR_WIDTH  = 32,
  localparam int unsigned STEP_AW   = $clog2(NUM_STEPS)
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [STEP_AW-1:0]    wr_addr,
  input  logic [PINC_WIDTH-1:0] wr_pinc,
  input  logic [3:0]            wr_type,
  input  logic [AMP_WIDTH-1:0]  wr_amp,
  input  logic [DUR_WIDTH-1:0]  wr_dur,
  input  logic [STEP_AW-1:0]    cfg_last,
  input  logic [15:0]           cfg_repeat,
  input  logic                  start,
  input  logic                  stop,
  output logic [PINC_WIDTH-1:0] m_axis_pinc_tdata,
  output logic                  m_axis_pinc_tvalid,
  output logic [3:0]            sig_type,
  output logic [AMP_WIDTH-1:0]  amp,
  output logic                  gen_aresetn,
  output logic                  busy,
  output logic [STEP_AW-1:0]    step_idx,
  output logic                  done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  // Step table; deliberately not reset so contents survive aresetn.
  logic [PINC_WIDTH-1:0] tbl_pinc [NUM_STEPS];
  logic [3:0]            tbl_type [NUM_STEPS];
  logic [AMP_WIDTH-1:0]  tbl_amp  [NUM_STEPS];
  logic [DUR_WIDTH-1:0]  tbl_dur  [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_pinc[wr_addr] <= wr_pinc;
      tbl_type[wr_addr] <= wr_type;
      tbl_amp[wr_addr]  <= wr_amp;
      tbl_dur[wr_addr]  <= wr_dur;
    end
  end

  logic [1:0]            state_q;
  logic [STEP_AW-1:0]    last_q;
  logic [15:0]           repeat_q;
  logic [15:0]           pass_q;
  logic [DUR_WIDTH-1:0]  cnt_q;
  logic                  pf_q;
  logic [PINC_WIDTH-1:0] nxt_pinc_q;
  logic [3:0]            nxt_type_q;
  logic [AMP_WIDTH-1:0]  nxt_amp_q;
  logic [DUR_WIDTH-1:0]  nxt_dur_q;
  logic [PINC_WIDTH-1:0] pinc_q;
  logic                  tvalid_q;
  logic [3:0]            type_q;
  logic [AMP_WIDTH-1:0]  amp_q;
  logic [STEP_AW-1:0]    step_q;
  logic                  done_q;
  logic                  gen_n_q;
  logic                  gen_hold_q;

  logic                  is_fetch;
  logic                  is_run;
  logic                  wrap;
  logic                  final_pass;
  logic                  cnt_last;
  logic                  apply;
  logic                  finish;
  logic                  resync;
  logic [STEP_AW-1:0]    follow_idx;
  logic [STEP_AW-1:0]    rd_idx;
  logic [PINC_WIDTH-1:0] src_pinc;
  logic [3:0]            src_type;
  logic [AMP_WIDTH-1:0]  src_amp;
  logic [DUR_WIDTH-1:0]  src_dur;
  logic [DUR_WIDTH-1:0]  src_d;

  always_comb begin
    is_fetch   = (state_q == StFetch);
    is_run     = (state_q == StRun);
    wrap       = (step_q == last_q);
    follow_idx = wrap ? '0 : step_q + STEP_AW'(1);
    // FETCH reads entry 0; in RUN the same port prefetches the following entry.
    rd_idx     = is_fetch ? '0 : follow_idx;
    final_pass = wrap && (repeat_q != 16'd0) && (pass_q == repeat_q);
    cnt_last   = (cnt_q == DUR_WIDTH'(1));
    src_pinc   = is_fetch ? tbl_pinc[rd_idx] : nxt_pinc_q;
    src_type   = is_fetch ? tbl_type[rd_idx] : nxt_type_q;
    src_amp    = is_fetch ? tbl_amp[rd_idx]  : nxt_amp_q;
    src_dur    = is_fetch ? tbl_dur[rd_idx]  : nxt_dur_q;
    src_d      = (src_dur < DUR_WIDTH'(2)) ? DUR_WIDTH'(2) : src_dur;
    apply      = is_fetch || (is_run && cnt_last && !final_pass);
    finish     = is_run && cnt_last && final_pass;
    resync     = is_fetch || (src_type != type_q);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      last_q     <= '0;
      repeat_q   <= '0;
      pass_q     <= '0;
      cnt_q      <= '0;
      pf_q       <= 1'b0;
      nxt_pinc_q <= '0;
      nxt_type_q <= '0;
      nxt_amp_q  <= '0;
      nxt_dur_q  <= '0;
      pinc_q     <= '0;
      tvalid_q   <= 1'b0;
      type_q     <= '0;
      amp_q      <= '0;
      step_q     <= '0;
      done_q     <= 1'b0;
      gen_n_q    <= 1'b1;
      gen_hold_q <= 1'b0;
    end else begin
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;

      // Generator reset stays low for the apply cycle plus one more.
      if (!gen_n_q) begin
        if (gen_hold_q) gen_hold_q <= 1'b0;
        else            gen_n_q    <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (start && !stop) begin
            last_q   <= cfg_last;
            repeat_q <= cfg_repeat;
            step_q   <= '0;
            pass_q   <= 16'd1;
            state_q  <= StFetch;
          end
        end

        StFetch, StRun: begin
          if (stop) begin
            state_q  <= StIdle;
            pinc_q   <= '0;
            amp_q    <= '0;
            tvalid_q <= 1'b1;
          end else if (apply) begin
            pinc_q   <= src_pinc;
            type_q   <= src_type;
            amp_q    <= src_amp;
            step_q   <= rd_idx;
            tvalid_q <= 1'b1;
            cnt_q    <= src_d;
            pf_q     <= 1'b1;
            state_q  <= StRun;
            if (is_run && wrap) pass_q <= pass_q + 16'd1;
            if (resync) begin
              gen_n_q    <= 1'b0;
              gen_hold_q <= 1'b1;
            end
          end else if (finish) begin
            state_q  <= StIdle;
            pinc_q   <= '0;
            amp_q    <= '0;
            tvalid_q <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - DUR_WIDTH'(1);
            if (pf_q) begin
              nxt_pinc_q <= tbl_pinc[rd_idx];
              nxt_type_q <= tbl_type[rd_idx];
              nxt_amp_q  <= tbl_amp[rd_idx];
              nxt_dur_q  <= tbl_dur[rd_idx];
              pf_q       <= 1'b0;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_pinc_tdata  = pinc_q;
  assign m_axis_pinc_tvalid = tvalid_q;
  assign sig_type           = type_q;
  assign amp                = amp_q;
  assign gen_aresetn        = gen_n_q & aresetn;
  assign busy               = (state_q != StIdle);
  assign step_idx           = step_q;
  assign done               = done_q;

endmodule

// File: tb/tb_sig_gen_sequencer.sv
// Directed bench for sig_gen_sequencer: per-cycle traces compared against hand-derived timelines.
module tb_sig_gen_sequencer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_pinc;
  logic [3:0]  wr_type;
  logic [15:0] wr_amp;
  logic [31:0] wr_dur;
  logic [2:0]  cfg_last;
  logic [15:0] cfg_repeat;
  logic        start;
  logic        stop;
  logic [31:0] m_axis_pinc_tdata;
  logic        m_axis_pinc_tvalid;
  logic [3:0]  sig_type;
  logic [15:0] amp;
  logic        gen_aresetn;
  logic        busy;
  logic [2:0]  step_idx;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] t_pinc [0:63];
  logic [3:0]  t_type [0:63];
  logic [15:0] t_amp  [0:63];
  logic        t_tv   [0:63];
  logic        t_gen  [0:63];
  logic        t_done [0:63];
  logic        t_busy [0:63];
  logic [2:0]  t_step [0:63];

  sig_gen_sequencer dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_pinc            (wr_pinc),
    .wr_type            (wr_type),
    .wr_amp             (wr_amp),
    .wr_dur             (wr_dur),
    .cfg_last           (cfg_last),
    .cfg_repeat         (cfg_repeat),
    .start              (start),
    .stop               (stop),
    .m_axis_pinc_tdata  (m_axis_pinc_tdata),
    .m_axis_pinc_tvalid (m_axis_pinc_tvalid),
    .sig_type           (sig_type),
    .amp                (amp),
    .gen_aresetn        (gen_aresetn),
    .busy               (busy),
    .step_idx           (step_idx),
    .done               (done)
  );

  always #4 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [31:0] p, input logic [3:0] t,
                             input logic [15:0] m, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_pinc = p; wr_type = t; wr_amp = m; wr_dur = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  // Leaves the bench in cycle 1 (start was sampled on the edge just passed).
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Samples cycles c0..c1; optionally writes entry w_addr (type 0, dur 6) during cycle w_cyc.
  task automatic trace(input int c0, input int c1, input int w_cyc, input logic [2:0] w_addr,
                       input logic [31:0] w_val);
    for (int c = c0; c <= c1; c++) begin
      t_pinc[c] = m_axis_pinc_tdata;
      t_type[c] = sig_type;
      t_amp[c]  = amp;
      t_tv[c]   = m_axis_pinc_tvalid;
      t_gen[c]  = gen_aresetn;
      t_done[c] = done;
      t_busy[c] = busy;
      t_step[c] = step_idx;
      if (c == w_cyc) begin
        wr_en = 1'b1; wr_addr = w_addr; wr_pinc = w_val; wr_type = 4'd0;
        wr_amp = w_val[15:0]; wr_dur = 32'd6;
      end
      tick(1);
      wr_en = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    aresetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_pinc = '0; wr_type = '0; wr_amp = '0;
    wr_dur = '0; cfg_last = '0; cfg_repeat = '0; start = 1'b0; stop = 1'b0;
    tick(3);

    // Reset values
    check_eq("rst_pinc", m_axis_pinc_tdata, 0);
    check_eq("rst_tvalid", m_axis_pinc_tvalid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gen_low", gen_aresetn, 0);
    check_eq("rst_done", done, 0);
    aresetn = 1'b1;
    #1;
    check_eq("rst_gen_release", gen_aresetn, 1);
    tick(1);

    // Single step, dur 10
    write_entry(3'd0, 32'h0100_0000, 4'd0, 16'h8000, 32'd10);
    cfg_last = 3'd0; cfg_repeat = 16'd1;
    pulse_start();
    trace(1, 13, 0, 3'd0, 32'd0);
    check_eq("s1_busy_k1", t_busy[1], 1);
    check_eq("s1_tv_k1", t_tv[1], 0);
    check_eq("s1_pinc_k2", t_pinc[2], 32'h0100_0000);
    check_eq("s1_amp_k2", t_amp[2], 16'h8000);
    check_eq("s1_tv_k2", t_tv[2], 1);
    check_eq("s1_gen_k2", t_gen[2], 0);
    check_eq("s1_gen_k3", t_gen[3], 0);
    check_eq("s1_gen_k4", t_gen[4], 1);
    check_eq("s1_tv_k3", t_tv[3], 0);
    check_eq("s1_pinc_k11", t_pinc[11], 32'h0100_0000);
    check_eq("s1_done_k11", t_done[11], 0);
    check_eq("s1_busy_k11", t_busy[11], 1);
    check_eq("s1_done_k12", t_done[12], 1);
    check_eq("s1_pinc_k12", t_pinc[12], 0);
    check_eq("s1_tv_k12", t_tv[12], 1);
    check_eq("s1_amp_k12", t_amp[12], 0);
    check_eq("s1_busy_k12", t_busy[12], 0);
    check_eq("s1_done_k13", t_done[13], 0);

    // Start while busy is ignored, including its cfg values
    pulse_start();
    tick(1);
    start = 1'b1; cfg_last = 3'd1; cfg_repeat = 16'd3;
    tick(1);
    start = 1'b0;
    trace(3, 13, 0, 3'd0, 32'd0);
    check_eq("sb_done_k11", t_done[11], 0);
    check_eq("sb_done_k12", t_done[12], 1);
    check_eq("sb_busy_k12", t_busy[12], 0);

    // Start and stop together stays idle
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check_eq("ss_busy1", busy, 0);
    tick(2);
    check_eq("ss_busy3", busy, 0);
    check_eq("ss_tvalid", m_axis_pinc_tvalid, 0);

    // Three steps, types 0,0,2, durs 5,0,7, two passes
    write_entry(3'd0, 32'h111, 4'd0, 16'h1000, 32'd5);
    write_entry(3'd1, 32'h222, 4'd0, 16'h2000, 32'd0);
    write_entry(3'd2, 32'h333, 4'd2, 16'h3000, 32'd7);
    cfg_last = 3'd2; cfg_repeat = 16'd2;
    pulse_start();
    trace(1, 31, 0, 3'd0, 32'd0);
    check_eq("m3_pinc_2", t_pinc[2], 32'h111);
    check_eq("m3_pinc_6", t_pinc[6], 32'h111);
    check_eq("m3_pinc_7", t_pinc[7], 32'h222);
    check_eq("m3_step_7", t_step[7], 1);
    check_eq("m3_pinc_8", t_pinc[8], 32'h222);
    check_eq("m3_pinc_9", t_pinc[9], 32'h333);
    check_eq("m3_type_9", t_type[9], 2);
    check_eq("m3_pinc_15", t_pinc[15], 32'h333);
    check_eq("m3_pinc_16", t_pinc[16], 32'h111);
    check_eq("m3_type_16", t_type[16], 0);
    check_eq("m3_step_23", t_step[23], 2);
    check_eq("m3_pinc_29", t_pinc[29], 32'h333);
    check_eq("m3_gen_3", t_gen[3], 0);
    check_eq("m3_gen_4", t_gen[4], 1);
    check_eq("m3_gen_7", t_gen[7], 1);
    check_eq("m3_gen_9", t_gen[9], 0);
    check_eq("m3_gen_10", t_gen[10], 0);
    check_eq("m3_gen_11", t_gen[11], 1);
    check_eq("m3_gen_16", t_gen[16], 0);
    check_eq("m3_gen_21", t_gen[21], 1);
    check_eq("m3_gen_23", t_gen[23], 0);
    check_eq("m3_done_30", t_done[30], 1);
    check_eq("m3_pinc_30", t_pinc[30], 0);
    check_eq("m3_amp_30", t_amp[30], 0);
    check_eq("m3_type_30", t_type[30], 2);
    check_eq("m3_busy_30", t_busy[30], 0);
    cnt = 0;
    for (int c = 2; c <= 30; c++) cnt += int'(t_tv[c]);
    check_eq("m3_tvalid_count", cnt, 7);
    cnt = 0;
    for (int c = 1; c <= 29; c++) cnt += int'(t_done[c]);
    check_eq("m3_early_done", cnt, 0);

    // Infinite repeat, pass length 3+4, then stop mid-step
    write_entry(3'd0, 32'hA, 4'd1, 16'h0100, 32'd3);
    write_entry(3'd1, 32'hB, 4'd3, 16'h0200, 32'd4);
    cfg_last = 3'd1; cfg_repeat = 16'd0;
    pulse_start();
    trace(1, 51, 0, 3'd0, 32'd0);
    cnt = 0;
    for (int c = 1; c <= 51; c++) cnt += int'(t_done[c]);
    check_eq("inf_no_done", cnt, 0);
    check_eq("inf_pinc_44", t_pinc[44], 32'hA);
    check_eq("inf_tv_44", t_tv[44], 1);
    check_eq("inf_pinc_48", t_pinc[48], 32'hB);
    check_eq("inf_step_48", t_step[48], 1);
    check_eq("inf_pinc_51", t_pinc[51], 32'hA);
    check_eq("inf_gen_51", t_gen[51], 0);
    check_eq("inf_busy_51", t_busy[51], 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check_eq("stop_pinc", m_axis_pinc_tdata, 0);
    check_eq("stop_amp", amp, 0);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_tvalid", m_axis_pinc_tvalid, 1);
    check_eq("stop_done", done, 0);
    tick(1);
    check_eq("stop_tvalid_after", m_axis_pinc_tvalid, 0);
    check_eq("stop_busy_after", busy, 0);

    // Writes to a running entry only show on the next pass
    write_entry(3'd0, 32'h10, 4'd0, 16'h0010, 32'd6);
    write_entry(3'd1, 32'h20, 4'd0, 16'h0020, 32'd6);
    cfg_last = 3'd1; cfg_repeat = 16'd2;
    pulse_start();
    trace(1, 9, 4, 3'd0, 32'h50);
    trace(10, 27, 10, 3'd1, 32'h60);
    check_eq("wr_pinc_5", t_pinc[5], 32'h10);
    check_eq("wr_pinc_8", t_pinc[8], 32'h20);
    check_eq("wr_pinc_11", t_pinc[11], 32'h20);
    check_eq("wr_pinc_14", t_pinc[14], 32'h50);
    check_eq("wr_amp_14", t_amp[14], 16'h0050);
    check_eq("wr_pinc_20", t_pinc[20], 32'h60);
    check_eq("wr_done_26", t_done[26], 1);

    // Reset mid-run, then the table still plays
    pulse_start();
    tick(4);
    aresetn = 1'b0;
    tick(4);
    check_eq("mr_pinc", m_axis_pinc_tdata, 0);
    check_eq("mr_amp", amp, 0);
    check_eq("mr_type", sig_type, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_step", step_idx, 0);
    check_eq("mr_gen", gen_aresetn, 0);
    check_eq("mr_tvalid", m_axis_pinc_tvalid, 0);
    aresetn = 1'b1;
    #1;
    check_eq("mr_gen_release", gen_aresetn, 1);
    tick(1);
    pulse_start();
    tick(1);
    check_eq("mr_replay_pinc", m_axis_pinc_tdata, 32'h50);
    check_eq("mr_replay_amp", amp, 16'h0050);
    check_eq("mr_replay_tv", m_axis_pinc_tvalid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
